// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the board-level reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SEQUENCE  = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int count_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int seq_cnt_width(input int hold_cycles, input int num_domains,
                                       input int stagger_cycles);
    return count_width(hold_cycles + (num_domains - 1) * stagger_cycles);
  endfunction

endpackage

// File: rtl/req_filter.sv
// Reset-request conditioning: synchroniser, debouncer and a one-cycle pulse on
// every debounced rising edge.
module req_filter
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic trig
);

  localparam int DB_W = count_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   level_q;
  logic [DB_W-1:0]        db_cnt_q;

  assign synced = sync_q[SYNC_STAGES-1];

  // Any sample matching the filtered level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      trig     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
      trig   <= 1'b0;
      if (synced == level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q  <= synced;
        db_cnt_q <= '0;
        trig     <= synced;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board-level reset controller: waits for PLL lock, then releases domain resets
// in staggered order. Optional watchdog enabled by RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_SOURCES     = 2,
  parameter int NUM_DOMAINS     = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8,
  parameter int STAGGER_CYCLES  = 4,
  parameter int WDT_CYCLES      = 1024
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   locked_in,
  input  logic [NUM_SOURCES-1:0] req_in,
  input  logic                   cause_clear_in,
  input  logic                   wdt_kick_in,
  output logic [NUM_DOMAINS-1:0] domain_reset_out,
  output logic                   busy_out,
  output logic [NUM_SOURCES:0]   cause_out
);

  localparam int TOTAL = HOLD_CYCLES + (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int CNT_W = seq_cnt_width(HOLD_CYCLES, NUM_DOMAINS, STAGGER_CYCLES);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W:0]         cnt_inc;
  logic [NUM_DOMAINS-1:0] dom_d;
  logic [NUM_SOURCES:0]   cause_d;
  logic [NUM_SOURCES-1:0] trig;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;
  logic                   any_trig;
  logic                   wdt_expire;

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
    req_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
      .clk  (clk_in),
      .rst_n(reset_in),
      .req  (req_in[g]),
      .trig (trig[g])
    );
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) lock_sync_q <= '0;
    else           lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked_in};
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int WDT_W = count_width(WDT_CYCLES);
  logic [WDT_W-1:0] wdt_q;

  assign wdt_expire = (state_q == RUN) && !wdt_kick_in && (wdt_q == WDT_W'(WDT_CYCLES - 1));

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in)                                          wdt_q <= '0;
    else if ((state_q != RUN) || wdt_kick_in || wdt_expire) wdt_q <= '0;
    else                                                    wdt_q <= wdt_q + WDT_W'(1);
  end
`else
  // Kick input and timeout parameter have no function without the watchdog.
  logic unused_wdt;
  assign unused_wdt = wdt_kick_in | (WDT_CYCLES < 1);
  assign wdt_expire = 1'b0;
`endif

  assign any_trig = (|trig) | wdt_expire;
  assign busy_out = (state_q != RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dom_d   = domain_reset_out;
    cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    unique case (state_q)
      WAIT_LOCK: begin
        dom_d = '0;
        cnt_d = '0;
        if (lock_s) state_d = SEQUENCE;
      end
      SEQUENCE: begin
        if (any_trig) begin
          cnt_d = '0;
          dom_d = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (int'(cnt_inc) >= HOLD_CYCLES + i * STAGGER_CYCLES) dom_d[i] = 1'b1;
          end
          if (int'(cnt_inc) == TOTAL) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        if (any_trig) begin
          state_d = SEQUENCE;
          cnt_d   = '0;
          dom_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        dom_d   = '0;
      end
    endcase
    // Lock loss overrides any trigger in the same cycle.
    if (!lock_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      dom_d   = '0;
    end
  end

  // A new cause in the same cycle as a clear survives the clear.
  assign cause_d = (cause_clear_in ? '0 : cause_out) | {wdt_expire, trig};

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q          <= WAIT_LOCK;
      cnt_q            <= '0;
      domain_reset_out <= '0;
      cause_out        <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      domain_reset_out <= dom_d;
      cause_out        <= cause_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters; the watchdog
// section follows RESET_SEQ_WATCHDOG_EN.
module tb_reset_sequencer;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       locked_in;
  logic [1:0] req_in;
  logic       cause_clear_in;
  logic       wdt_kick_in;
  logic [1:0] domain_reset_out;
  logic       busy_out;
  logic [2:0] cause_out;

  int n_checks = 0;
  int n_fail   = 0;
  int c0, c1, cb, cd, bad;

  always #5 clk_in = ~clk_in;

  reset_sequencer #(
    .NUM_SOURCES    (2),
    .NUM_DOMAINS    (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16),
    .HOLD_CYCLES    (8),
    .STAGGER_CYCLES (4),
    .WDT_CYCLES     (1024)
  ) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .locked_in       (locked_in),
    .req_in          (req_in),
    .cause_clear_in  (cause_clear_in),
    .wdt_kick_in     (wdt_kick_in),
    .domain_reset_out(domain_reset_out),
    .busy_out        (busy_out),
    .cause_out       (cause_out)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Negedges until domain 0 / domain 1 release and busy falls (-1 = never).
  task automatic wait_release(output int r0, output int r1, output int rb);
    r0 = -1; r1 = -1; rb = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk_in);
      if (r0 < 0 && domain_reset_out[0]) r0 = k;
      if (r1 < 0 && domain_reset_out[1]) r1 = k;
      if (rb < 0 && !busy_out) rb = k;
      if (r1 >= 0 && rb >= 0) break;
    end
  endtask

  task automatic wait_drop(input int limit, output int d);
    d = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk_in);
      if (!domain_reset_out[0]) begin
        d = k;
        break;
      end
    end
  endtask

  task automatic quiet(input int n, output int nbad);
    nbad = 0;
    repeat (n) begin
      @(negedge clk_in);
      if (domain_reset_out != 2'b11 || busy_out) nbad++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_in = 1'b0; locked_in = 1'b1; req_in = 2'b00;
    cause_clear_in = 1'b0; wdt_kick_in = 1'b0;
    cycles(3);
    check("rst_dom", int'(domain_reset_out), 0);
    check("rst_busy", int'(busy_out), 1);
    check("rst_cause", int'(cause_out), 0);

    // Power-up: 2 sync edges, entry on 3rd, releases at +8 / +12
    reset_in = 1'b1;
    wait_release(c0, c1, cb);
    check("pwr_dom0", c0, 11);
    check("pwr_dom1", c1, 15);
    check("pwr_busy", cb, 15);
    check("pwr_cause", int'(cause_out), 0);

    // Bouncing request never reaches the debounce count
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (k % 5 == 0) req_in[0] = ~req_in[0];
      @(negedge clk_in);
      if (domain_reset_out != 2'b11 || busy_out) bad++;
    end
    quiet(10, cd);
    check("bounce_no_reset", bad + cd, 0);

    // Held request: 2 sync + 16 debounce -> pulse, FSM reacts one edge later
    req_in[0] = 1'b1;
    wait_drop(100, cd);
    check("req0_drop", cd, 19);
    wait_release(c0, c1, cb);
    check("req0_dom0", c0, 8);
    check("req0_dom1", c1, 12);
    check("req0_busy", cb, 12);
    check("req0_cause", int'(cause_out), 1);
    quiet(30, bad);
    check("req0_single", bad, 0);
    req_in[0] = 1'b0;
    quiet(25, bad);
    check("req0_fall_quiet", bad, 0);

    // Restart mid-sequence: req1 pulse lands while counter is 10
    req_in[0] = 1'b1;
    cycles(11);
    req_in[1] = 1'b1;
    cycles(18);
    check("mid_dom_before", int'(domain_reset_out), 1);
    wait_drop(5, cd);
    check("mid_drop", cd, 1);
    check("mid_dom_all0", int'(domain_reset_out), 0);
    wait_release(c0, c1, cb);
    check("mid_dom0", c0, 8);
    check("mid_dom1", c1, 12);
    check("mid_cause", int'(cause_out), 3);
    req_in = 2'b00;
    quiet(25, bad);
    check("mid_fall_quiet", bad, 0);

    // Lock loss
    locked_in = 1'b0;
    wait_drop(10, cd);
    check("lock_drop", cd, 3);
    check("lock_dom_all0", int'(domain_reset_out), 0);
    bad = 0;
    repeat (17) begin
      @(negedge clk_in);
      if (domain_reset_out != 2'b00 || !busy_out) bad++;
    end
    check("lock_hold", bad, 0);
    locked_in = 1'b1;
    wait_release(c0, c1, cb);
    check("relock_dom0", c0, 11);
    check("relock_dom1", c1, 15);
    check("relock_busy", cb, 15);
    check("relock_cause", int'(cause_out), 3);

    // Cause clear versus simultaneous set
    cause_clear_in = 1'b1;
    @(negedge clk_in);
    cause_clear_in = 1'b0;
    check("clear_alone_a", int'(cause_out), 0);
    req_in = 2'b11;
    cycles(18);
    cause_clear_in = 1'b1;
    @(negedge clk_in);
    cause_clear_in = 1'b0;
    check("clear_vs_set", int'(cause_out), 3);
    check("dual_dom_all0", int'(domain_reset_out), 0);
    wait_release(c0, c1, cb);
    check("dual_dom0", c0, 8);
    check("dual_dom1", c1, 12);
    req_in = 2'b00;
    cycles(25);
    cause_clear_in = 1'b1;
    @(negedge clk_in);
    cause_clear_in = 1'b0;
    check("clear_alone_b", int'(cause_out), 0);

    // Asynchronous reset between clock edges in mid-sequence
    req_in[0] = 1'b1;
    wait_drop(40, cd);
    check("t6_drop", cd, 19);
    cycles(9);
    check("t6_mid", int'(domain_reset_out), 1);
    check("t6_cause_pre", int'(cause_out), 1);
    req_in[0] = 1'b0;
    #1 reset_in = 1'b0;
    #1;
    check("arst_dom", int'(domain_reset_out), 0);
    check("arst_busy", int'(busy_out), 1);
    check("arst_cause", int'(cause_out), 0);
    reset_in = 1'b1;
    wait_release(c0, c1, cb);
    check("arst_dom0", c0, 11);
    check("arst_dom1", c1, 15);

`ifdef RESET_SEQ_WATCHDOG_EN
    wait_drop(1100, cd);
    check("wdt_drop", cd, 1024);
    check("wdt_cause", int'(cause_out), 4);
    wait_release(c0, c1, cb);
    check("wdt_dom1", c1, 12);
    bad = 0;
    for (int k = 0; k < 1500; k++) begin
      wdt_kick_in = (k % 600 == 599);
      @(negedge clk_in);
      if (domain_reset_out != 2'b11 || busy_out) bad++;
    end
    wdt_kick_in = 1'b0;
    check("wdt_kicked", bad, 0);
`else
    quiet(1100, bad);
    check("no_wdt_quiet", bad, 0);
    check("no_wdt_cause", int'(cause_out), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised board-level reset controller that replaces the ad-hoc button/PLL reset glue in FPGA top-levels. It synchronises and debounces NUM_SOURCES asynchronous reset-request inputs and synchronises the PLL lock. It then drives NUM_DOMAINS active-low domain resets, holding them for a fixed count and releasing them in staggered order. Sits between clock generation and the SoC; records the cause of the last reset.

Parameters:
NUM_SOURCES, 2, number of reset-request inputs (buttons etc.)
NUM_DOMAINS, 2, number of sequenced reset outputs
SYNC_STAGES, 2, flip-flop stages in every input synchroniser (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to change a filtered request level
HOLD_CYCLES, 8, cycles domain 0 is held in reset after a trigger (>=1)
STAGGER_CYCLES, 4, extra cycles between release of domain i and domain i+1
WDT_CYCLES, 1024, watchdog timeout; used only with RESET_SEQ_WATCHDOG_EN

Ports:
clk_in  input  1  system clock (post-PLL)
reset_in  input  1  asynchronous, active-low reset
locked_in  input  1  PLL lock, asynchronous
req_in  input  NUM_SOURCES  asynchronous active-high reset requests
cause_clear_in  input  1  synchronous clear of cause_out
wdt_kick_in  input  1  watchdog kick, synchronous; ignored without macro
domain_reset_out  output  NUM_DOMAINS  active-low domain resets, registered
busy_out  output  1  high while any domain is in reset
cause_out  output  NUM_SOURCES+1  sticky cause bits; bit i = req_in[i], MSB = watchdog

Behaviour:
- reset_in low (async): state WAIT_LOCK, domain_reset_out all 0, busy_out 1, cause_out 0, filters cleared (filtered level 0), counter 0.
- Per source: SYNC_STAGES synchroniser, then debouncer. The filtered level flips only after the synced input has held the opposite value for DEBOUNCE_CYCLES consecutive cycles. Trigger = one-cycle pulse on a filtered 0->1 edge. A request held high gives exactly one trigger.
- locked_in passes through SYNC_STAGES, with no debounce.
- FSM states: WAIT_LOCK, SEQUENCE, RUN.
- WAIT_LOCK: all outputs 0. On synced lock high, the next edge enters SEQUENCE with counter 0. Triggers here set cause bits only.
- SEQUENCE: the counter increments every cycle. Counter width is clog2(HOLD_CYCLES+(NUM_DOMAINS-1)*STAGGER_CYCLES+1).
  - domain_reset_out[i] goes 1 exactly HOLD_CYCLES+i*STAGGER_CYCLES cycles after SEQUENCE entry; released domains stay 1.
  - When the last domain is released, the same edge enters RUN and drops busy_out.
- RUN: any trigger (or watchdog expiry) causes the next edge to do all of the following: enter SEQUENCE, zero the counter, drive all domains 0, raise busy_out.
- Trigger during SEQUENCE: the sequence restarts from counter 0 and already-released domains re-assert on the next edge.
- Synced lock low in any state: the next edge enters WAIT_LOCK with all domains 0. Lock loss has priority over triggers.
- cause_out:
  - A trigger sets its bit; bits are sticky across sequences.
  - cause_clear_in clears all bits, except that a set in the same cycle wins.
  - Multiple simultaneous triggers set all of their bits.
- busy_out = 1 in WAIT_LOCK and SEQUENCE, 0 in RUN.

Optional Feature:
RESET_SEQ_WATCHDOG_EN defined:
- A watchdog counter runs only in RUN; it is cleared by wdt_kick_in and on leaving RUN.
- Reaching WDT_CYCLES without a kick acts as a trigger and sets cause_out MSB.
Undefined:
- No watchdog logic; wdt_kick_in is ignored and cause_out MSB is constant 0.

Decomposition:
- Package reset_seq_pkg: state enum (WAIT_LOCK, SEQUENCE, RUN) and a function computing counter width from the parameters.
- Sub-module req_filter (synchroniser, debouncer, rising-edge pulse), instantiated once per source via generate.
- The lock synchroniser is a plain SYNC_STAGES shift register inside reset_sequencer.

Test Plan:
1. Release reset_in with locked_in=1 → SEQUENCE entered after sync latency; domain_reset_out[0] rises 8 cycles later and [1] 12 cycles later; busy_out falls with [1]; cause_out=0.
2. req_in[0] toggling every 5 cycles for 60 cycles in RUN → no reset. Then held high 16+ cycles → exactly one sequence (8/12 timing), cause_out=3'b001.
3. req_in[1] trigger while SEQUENCE counter=10 (domain0 already released) → domain0 low next edge, restart gives 8/12 releases, cause_out[1]=1.
4. locked_in dropped for 20 cycles in RUN → all domains 0 within SYNC_STAGES+1 cycles, WAIT_LOCK. Lock restored → full sequence.
5. Triggers on req_in[0] and req_in[1] in the same cycle as cause_clear_in → cause_out=3'b011. A later clear alone → 3'b000.
6. reset_in pulsed low mid-SEQUENCE between clock edges → outputs 0 immediately. With RESET_SEQ_WATCHDOG_EN and no kicks for 1024 cycles in RUN → a sequence runs and cause_out=3'b100.
